div_64_seq: RTL and testbench

- Request/response sequencer directly upstream and downstream of the 64-bit iterative divider core.
- Accepts signed or unsigned 64-bit divide requests on a valid/ready interface, converts signed operands to magnitudes, and resolves the special cases itself: divide-by-zero, signed overflow, and |X|<|Y|.
- For all other requests it drives the core's start/operand inputs, holds them for the whole operation, captures the core's {Q,R} result, applies sign correction, and presents the result on a valid/ready response interface.

---
 rtl/div_64_seq.sv | 206 ++++++++++++++++++++
 tb/tb_div_64_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_64_seq.sv
// Request/response sequencer wrapped around the 64-bit iterative divider core.
// Optional core watchdog is enabled by defining DIV_SEQ_TIMEOUT_EN.
module div_64_seq #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 80
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_signed_i,
  input  logic [63:0]       req_x_i,
  input  logic [63:0]       req_y_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              div_start_o,
  output logic [63:0]       div_x_o,
  output logic [63:0]       div_y_o,
  input  logic              div_rdy_i,
  input  logic [127:0]      div_qr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [63:0]       rsp_q_o,
  output logic [63:0]       rsp_r_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] ONES = '1;
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, POST, RSP} state_t;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return DATA_W'(0) - v;
  endfunction

  state_t state, state_nx;
  logic [DATA_W-1:0] x_r, x_nx, y_r, y_nx;
  logic              sgn_r, sgn_nx, sx_r, sx_nx, sy_r, sy_nx;
  logic [TAG_W-1:0]  tag_nx;
  logic [DATA_W-1:0] dx_nx, dy_nx, q_nx, r_nx;
  logic              start_nx, valid_nx, ready_nx, busy_nx;
  logic              sx_c, sy_c;
  logic [DATA_W-1:0] ax_c, ay_c;

`ifdef DIV_SEQ_TIMEOUT_EN
  localparam logic [6:0] CNT_LIM = 7'(TIMEOUT - 1);
  logic [6:0] cnt_r, cnt_nx;
  logic       err_nx;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Operand magnitudes; unsigned requests never negate.
  assign sx_c = sgn_r & x_r[DATA_W-1];
  assign sy_c = sgn_r & y_r[DATA_W-1];
  assign ax_c = sx_c ? neg(x_r) : x_r;
  assign ay_c = sy_c ? neg(y_r) : y_r;

  always_comb begin
    state_nx = state;
    x_nx     = x_r;
    y_nx     = y_r;
    sgn_nx   = sgn_r;
    tag_nx   = rsp_tag_o;
    sx_nx    = sx_r;
    sy_nx    = sy_r;
    dx_nx    = div_x_o;
    dy_nx    = div_y_o;
    start_nx = div_start_o;
    q_nx     = rsp_q_o;
    r_nx     = rsp_r_o;
    valid_nx = rsp_valid_o;
`ifdef DIV_SEQ_TIMEOUT_EN
    cnt_nx   = cnt_r;
    err_nx   = rsp_err_o;
`endif
    unique case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          x_nx     = req_x_i;
          y_nx     = req_y_i;
          sgn_nx   = req_signed_i;
          tag_nx   = req_tag_i;
          state_nx = PREP;
        end
      end
      // PREP: special cases resolve here without ever touching the core
      PREP: begin
        sx_nx = sx_c;
        sy_nx = sy_c;
        if (y_r == '0) begin
          q_nx     = ONES;
          r_nx     = x_r;
          valid_nx = 1'b1;
          state_nx = RSP;
        end else if (sgn_r && x_r == SMIN && y_r == ONES) begin
          q_nx     = x_r;
          r_nx     = '0;
          valid_nx = 1'b1;
          state_nx = RSP;
        end else if (ax_c < ay_c) begin
          q_nx     = '0;
          r_nx     = x_r;
          valid_nx = 1'b1;
          state_nx = RSP;
        end else begin
          dx_nx    = ax_c;
          dy_nx    = ay_c;
          start_nx = 1'b1;
`ifdef DIV_SEQ_TIMEOUT_EN
          cnt_nx   = '0;
`endif
          state_nx = DIV;
        end
      end
      // DIV: core operands and start held until the first done
      DIV: begin
        if (div_rdy_i) begin
          q_nx     = div_qr_i[127:64];
          r_nx     = div_qr_i[63:0];
          start_nx = 1'b0;
          state_nx = POST;
        end
`ifdef DIV_SEQ_TIMEOUT_EN
        else if (cnt_r == CNT_LIM) begin
          q_nx     = '0;
          r_nx     = '0;
          start_nx = 1'b0;
          err_nx   = 1'b1;
          valid_nx = 1'b1;
          state_nx = RSP;
        end else begin
          cnt_nx = cnt_r + 7'd1;
        end
`endif
      end
      // POST: restore signs; remainder follows the dividend
      POST: begin
        q_nx     = (sx_r ^ sy_r) ? neg(rsp_q_o) : rsp_q_o;
        r_nx     = sx_r ? neg(rsp_r_o) : rsp_r_o;
        valid_nx = 1'b1;
        state_nx = RSP;
      end
      RSP: begin
        if (rsp_ready_i) begin
          valid_nx = 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      x_r         <= '0;
      y_r         <= '0;
      sgn_r       <= 1'b0;
      sx_r        <= 1'b0;
      sy_r        <= 1'b0;
      rsp_tag_o   <= '0;
      div_x_o     <= '0;
      div_y_o     <= '0;
      div_start_o <= 1'b0;
      rsp_q_o     <= '0;
      rsp_r_o     <= '0;
      rsp_valid_o <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
      cnt_r       <= '0;
      rsp_err_o   <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      x_r         <= x_nx;
      y_r         <= y_nx;
      sgn_r       <= sgn_nx;
      sx_r        <= sx_nx;
      sy_r        <= sy_nx;
      rsp_tag_o   <= tag_nx;
      div_x_o     <= dx_nx;
      div_y_o     <= dy_nx;
      div_start_o <= start_nx;
      rsp_q_o     <= q_nx;
      rsp_r_o     <= r_nx;
      rsp_valid_o <= valid_nx;
      req_ready_o <= ready_nx;
      busy_o      <= busy_nx;
`ifdef DIV_SEQ_TIMEOUT_EN
      cnt_r       <= cnt_nx;
      rsp_err_o   <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_div_64_seq.sv
// Self-checking bench for div_64_seq: table-driven requests, a behavioural
// divider core, a response scoreboard, and backpressure/reset/timeout sequences.
module tb_div_64_seq;
  localparam int TAG_W = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              req_valid_i, req_ready_o, req_signed_i;
  logic [63:0]       req_x_i, req_y_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic              div_start_o;
  logic [63:0]       div_x_o, div_y_o;
  logic              div_rdy_i = 1'b0;
  logic [127:0]      div_qr_i = '0;
  logic              rsp_valid_o, rsp_ready_i;
  logic [63:0]       rsp_q_o, rsp_r_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic              rsp_err_o, busy_o;

  div_64_seq #(.TAG_W(TAG_W), .TIMEOUT(80)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_signed_i(req_signed_i),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .req_tag_i(req_tag_i),
    .div_start_o(div_start_o), .div_x_o(div_x_o), .div_y_o(div_y_o),
    .div_rdy_i(div_rdy_i), .div_qr_i(div_qr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_q_o(rsp_q_o), .rsp_r_o(rsp_r_o), .rsp_tag_o(rsp_tag_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = special (core never started), 1 = core path, 2 = core timeout
  typedef struct {
    logic             sgn;
    logic [63:0]      x, y;
    logic [TAG_W-1:0] tag;
    logic [63:0]      q, r;
    int               kind, clat, lat;
    logic             err;
  } vec_t;
  typedef struct {
    logic [63:0]      q, r;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  vec_t tv[10];
  int total = 0, bad = 0;

  // Behavioural core: raises done core_lat cycles after start, 0 = never.
  int core_lat = 3, cyc = 0;
  int after_rdy_n = 0, after_rdy_err = 0, hold_err = 0, start_cnt = 0;
  logic [63:0] hx = '0, hy = '0;
  always @(negedge clk_i) begin
    if (div_rdy_i) begin
      after_rdy_n++;
      if (div_start_o) after_rdy_err++;
    end
    if (div_start_o) begin
      start_cnt++;
      if (cyc > 0 && (div_x_o !== hx || div_y_o !== hy)) hold_err++;
      hx = div_x_o;
      hy = div_y_o;
      cyc++;
      div_rdy_i = (core_lat > 0) && (cyc >= core_lat);
      if (hy != 0) div_qr_i = {hx / hy, hx % hy};
    end else begin
      cyc = 0;
      div_rdy_i = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request, score its response; bp > 0 holds rsp_ready_i low that
  // many cycles while a competing request is offered.
  task automatic run(input vec_t v, input int bp);
    int n, lat, stab, sc0, an0;
    exp_t e;
    sc0 = start_cnt;
    an0 = after_rdy_n;
    @(negedge clk_i);
    core_lat     = v.clat;
    req_valid_i  = 1'b1;
    req_signed_i = v.sgn;
    req_x_i      = v.x;
    req_y_i      = v.y;
    req_tag_i    = v.tag;
    n = 0;
    while (!req_ready_o && n < 100) begin @(negedge clk_i); n++; end
    chk("accept", 64'(n < 100), 64'd1);
    @(posedge clk_i);
    sb.push_back('{q: v.q, r: v.r, tag: v.tag, err: v.err});
    lat = 1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("not_ready_after_accept", 64'(req_ready_o), 64'd0);
    while (!rsp_valid_o && lat < 300) begin
      @(posedge clk_i); lat++; @(negedge clk_i);
    end
    chk("latency", 64'(lat), 64'(v.lat));
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = sb.pop_front();
    chk("rsp_q", rsp_q_o, e.q);
    chk("rsp_r", rsp_r_o, e.r);
    chk("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
    chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
    chk("start_low_at_rsp", 64'(div_start_o), 64'd0);
    if (v.kind == 0) chk("no_core_start", 64'(start_cnt - sc0), 64'd0);
    if (v.kind == 1) begin
      chk("one_core_done", 64'(after_rdy_n - an0), 64'd1);
      chk("start_low_after_rdy", 64'(after_rdy_err), 64'd0);
      chk("start_operands_held", 64'(hold_err), 64'd0);
    end
    if (v.kind == 2) chk("timeout_div_cycles", 64'(start_cnt - sc0), 64'd80);
    if (bp > 0) begin
      stab = 0;
      req_valid_i  = 1'b1;
      req_signed_i = 1'b0;
      req_x_i      = 64'd200;
      req_y_i      = 64'd10;
      req_tag_i    = 4'd12;
      repeat (bp) begin
        @(negedge clk_i);
        if (!rsp_valid_o || rsp_q_o !== e.q || rsp_r_o !== e.r ||
            rsp_tag_o !== e.tag || req_ready_o !== 1'b0) stab++;
      end
      chk("bp_stable", 64'(stab), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("valid_drop", 64'(rsp_valid_o), 64'd0);
    chk("ready_back", 64'(req_ready_o), 64'd1);
    chk("busy_drop", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tv[0] = '{1'b0, 64'd100, 64'd7, 4'd3, 64'd14, 64'd2, 1, 3, 6, 1'b0};
    tv[1] = '{1'b1, -64'd100, 64'd7, 4'd1, -64'd14, -64'd2, 1, 5, 8, 1'b0};
    tv[2] = '{1'b1, 64'd100, -64'd7, 4'd2, -64'd14, 64'd2, 1, 1, 4, 1'b0};
    tv[3] = '{1'b0, 64'd55, 64'd0, 4'd4, '1, 64'd55, 0, 3, 2, 1'b0};
    tv[4] = '{1'b1, 64'h8000_0000_0000_0000, '1, 4'd5,
              64'h8000_0000_0000_0000, 64'd0, 0, 3, 2, 1'b0};
    tv[5] = '{1'b0, 64'd5, 64'd9, 4'd6, 64'd0, 64'd5, 0, 3, 2, 1'b0};
    tv[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 4'd7,
              64'h5555_5555_5555_5550, 64'd0, 1, 2, 5, 1'b0};
    tv[7] = '{1'b1, -64'd7, -64'd100, 4'd8, 64'd0, -64'd7, 0, 3, 2, 1'b0};
    tv[8] = '{1'b1, -64'd100, -64'd7, 4'd9, 64'd14, -64'd2, 1, 2, 5, 1'b0};
    tv[9] = '{1'b0, 64'h8000_0000_0000_0000, '1, 4'd10,
              64'd0, 64'h8000_0000_0000_0000, 0, 3, 2, 1'b0};

    reset_i = 1'b1; req_valid_i = 1'b0; req_signed_i = 1'b0;
    req_x_i = '0; req_y_i = '0; req_tag_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ready", 64'(req_ready_o), 64'd1);
    chk("reset_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_start", 64'(div_start_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_err", 64'(rsp_err_o), 64'd0);
    chk("reset_q", rsp_q_o, 64'd0);
    reset_i = 1'b0;

    for (int i = 0; i < 10; i++) run(tv[i], 0);

    // Backpressure with a competing request, then serve that request.
    v = tv[0];
    v.tag = 4'd11;
    run(v, 10);
    run('{1'b0, 64'd200, 64'd10, 4'd12, 64'd20, 64'd0, 1, 4, 7, 1'b0}, 0);

    // Reset in the fifth DIV cycle.
    @(negedge clk_i);
    core_lat = 20;
    req_valid_i = 1'b1; req_signed_i = 1'b0;
    req_x_i = 64'd1000; req_y_i = 64'd3; req_tag_i = 4'd5;
    while (!req_ready_o) @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("div5_start_high", 64'(div_start_o), 64'd1);
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("midreset_start", 64'(div_start_o), 64'd0);
    chk("midreset_valid", 64'(rsp_valid_o), 64'd0);
    chk("midreset_ready", 64'(req_ready_o), 64'd1);
    chk("midreset_busy", 64'(busy_o), 64'd0);
    chk("midreset_tag", 64'(rsp_tag_o), 64'd0);
    chk("midreset_divx", div_x_o, 64'd0);
    run('{1'b0, 64'd81, 64'd9, 4'd9, 64'd9, 64'd0, 1, 4, 7, 1'b0}, 0);

`ifdef DIV_SEQ_TIMEOUT_EN
    run('{1'b0, 64'd100, 64'd7, 4'd13, 64'd0, 64'd0, 2, 0, 82, 1'b1}, 0);
    chk("err_cleared", 64'(rsp_err_o), 64'd0);
`endif

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
